// File: rtl/arb_requester.sv
// Three independent job-queue requesters: each buffers up to two burst lengths and
// drives a registered request to a shared arbiter. Define ARB_REQ_TIMEOUT_EN for grant timeout.
module arb_requester (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  job_push,
  input  logic [11:0] job_len,
  input  logic [2:0]  get,
  output logic [2:0]  go,
  output logic [2:0]  beat,
  output logic [2:0]  done,
  output logic [2:0]  job_full,
  output logic [2:0]  busy,
  output logic [2:0]  err
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BURST = 2'd2} state_e;

  state_e     state_q [3];
  state_e     state_d [3];
  logic [3:0] fifo_q  [3][2];
  logic [3:0] fifo_d  [3][2];
  logic [1:0] cnt_q   [3];
  logic [1:0] cnt_d   [3];
  logic [4:0] rem_q   [3];
  logic [4:0] rem_d   [3];
  logic [3:0] head_c  [3];
  logic [2:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0] push_c, pop_c;
`ifdef ARB_REQ_TIMEOUT_EN
  logic [5:0] tmo_q [3];
  logic [5:0] tmo_d [3];
  logic [2:0] err_q, err_d;
`endif

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
`ifdef ARB_REQ_TIMEOUT_EN
    err_d = err_q;
`endif
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      rem_d[i]     = rem_q[i];
      fifo_d[i][0] = fifo_q[i][0];
      fifo_d[i][1] = fifo_q[i][1];
      head_c[i]    = fifo_q[i][rd_q[i]];
      // A push into a full buffer is lost even if the head is popped on the same edge
      push_c[i]    = job_push[i] && (cnt_q[i] != 2'd2);
      pop_c[i]     = 1'b0;
      beat[i]      = 1'b0;
      done[i]      = 1'b0;
      go[i]        = (state_q[i] != IDLE);
      busy[i]      = (state_q[i] != IDLE);
      job_full[i]  = (cnt_q[i] == 2'd2);

      case (state_q[i])
        IDLE: begin
          if (cnt_q[i] != 2'd0) begin
            pop_c[i]   = 1'b1;
            rem_d[i]   = (head_c[i] == 4'd0) ? 5'd16 : {1'b0, head_c[i]};
            state_d[i] = REQ;
          end
        end
        REQ, BURST: begin
          if (get[i]) begin
            beat[i]  = 1'b1;
            rem_d[i] = rem_q[i] - 5'd1;
            if (rem_q[i] == 5'd1) begin
              done[i]    = 1'b1;
              state_d[i] = IDLE;
            end else begin
              state_d[i] = BURST;
            end
          end
`ifdef ARB_REQ_TIMEOUT_EN
          else if ((state_q[i] == REQ) && (tmo_q[i] == 6'd62)) begin
            err_d[i]   = 1'b1;
            rem_d[i]   = 5'd0;
            state_d[i] = IDLE;
          end
`endif
        end
        default: state_d[i] = IDLE;
      endcase

`ifdef ARB_REQ_TIMEOUT_EN
      tmo_d[i] = ((state_q[i] == REQ) && (state_d[i] == REQ)) ? tmo_q[i] + 6'd1 : 6'd0;
`endif
      if (push_c[i]) begin
        fifo_d[i][wr_q[i]] = job_len[4*i +: 4];
        wr_d[i]            = ~wr_q[i];
      end
      if (pop_c[i]) rd_d[i] = ~rd_q[i];
      cnt_d[i] = cnt_q[i] + {1'b0, push_c[i]} - {1'b0, pop_c[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 3'b000;
      wr_q <= 3'b000;
`ifdef ARB_REQ_TIMEOUT_EN
      err_q <= 3'b000;
`endif
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= 2'd0;
        rem_q[i]   <= 5'd0;
`ifdef ARB_REQ_TIMEOUT_EN
        tmo_q[i]   <= 6'd0;
`endif
      end
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
`ifdef ARB_REQ_TIMEOUT_EN
      err_q <= err_d;
`endif
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rem_q[i]   <= rem_d[i];
`ifdef ARB_REQ_TIMEOUT_EN
        tmo_q[i]   <= tmo_d[i];
`endif
      end
    end
  end

  // Buffer storage carries data only; occupancy is tracked by the reset pointers/count
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      fifo_q[i][0] <= fifo_d[i][0];
      fifo_q[i][1] <= fifo_d[i][1];
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed testbench for arb_requester: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_arb_requester;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  job_push = 3'b000;
  logic [11:0] job_len = 12'h000;
  logic [2:0]  get = 3'b000;
  logic [2:0]  go, beat, done, job_full, busy, err;
  int checks = 0;
  int errors = 0;

  arb_requester dut (
    .clk(clk), .rst(rst), .job_push(job_push), .job_len(job_len), .get(get),
    .go(go), .beat(beat), .done(done), .job_full(job_full), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    next_cycle;
    rst = 1'b1; job_push = 3'b000; job_len = 12'h000; get = 3'b000;
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    @(negedge clk);
    checks++; if (go !== 3'b000 || busy !== 3'b000) begin errors++; $display("FAIL reset_init: got go=%b busy=%b expected 000 000", go, busy); end
    checks++; if (job_full !== 3'b000 || err !== 3'b000) begin errors++; $display("FAIL reset_init_flags: got full=%b err=%b expected 000 000", job_full, err); end
    next_cycle; job_push = 3'b111; job_len = 12'h333;
    next_cycle; job_push = 3'b111;
    next_cycle; job_push = 3'b000;
    @(negedge clk);
    checks++; if (go !== 3'b111) begin errors++; $display("FAIL reset_pre_go: got %b expected 111", go); end
    next_cycle; rst = 1'b1; get = 3'b111; job_push = 3'b111;
    next_cycle; rst = 1'b0; job_push = 3'b000;
    @(negedge clk);
    checks++; if (go !== 3'b000 || busy !== 3'b000 || job_full !== 3'b000 || err !== 3'b000) begin
      errors++; $display("FAIL reset_mid: got go=%b busy=%b full=%b err=%b expected all 000", go, busy, job_full, err); end
    checks++; if (beat !== 3'b000 || done !== 3'b000) begin errors++; $display("FAIL reset_mid_pulse: got beat=%b done=%b expected 000 000", beat, done); end
    for (int c = 0; c < 4; c++) begin
      next_cycle;
      @(negedge clk);
      checks++; if (go !== 3'b000 || beat !== 3'b000) begin errors++; $display("FAIL reset_discard c%0d: got go=%b beat=%b expected 000 000", c, go, beat); end
    end
    get = 3'b000;
  endtask

  // len=3 on ch0 with get[0] held high from the push onward
  task automatic test_len3;
    apply_reset;
    for (int c = 0; c <= 6; c++) begin
      next_cycle;
      job_push = (c == 0) ? 3'b001 : 3'b000;
      job_len  = 12'h003;
      get      = 3'b001;
      @(negedge clk);
      checks++;
      if (go[0] !== (c >= 2 && c <= 4) || beat[0] !== (c >= 2 && c <= 4) || done[0] !== (c == 4)) begin
        errors++; $display("FAIL len3 c%0d: got go=%b beat=%b done=%b expected %b %b %b", c, go[0], beat[0], done[0],
                            (c >= 2 && c <= 4), (c >= 2 && c <= 4), (c == 4));
      end
    end
    get = 3'b000;
  endtask

  task automatic test_len16;
    int nb, nd;
    apply_reset;
    nb = 0; nd = 0;
    for (int c = 0; c <= 20; c++) begin
      next_cycle;
      job_push = (c == 0) ? 3'b100 : 3'b000;
      job_len  = 12'h000;
      get      = 3'b100;
      @(negedge clk);
      if (beat[2]) nb++;
      if (done[2]) nd++;
      if (c == 17) begin
        checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL len16_last: got done=%b expected 1", done[2]); end
      end
    end
    checks++; if (nb != 16 || nd != 1) begin errors++; $display("FAIL len16_count: got beats=%0d dones=%0d expected 16 1", nb, nd); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL len16_busy: got %b expected 0", busy[2]); end
    get = 3'b000;
  endtask

  task automatic test_stall;
    logic [5:0] pat;
    apply_reset;
    pat = 6'b111001;  // bit k = grant on burst cycle k+1
    next_cycle; job_push = 3'b010; job_len = 12'h040;
    next_cycle; job_push = 3'b000;
    for (int k = 0; k < 6; k++) begin
      next_cycle;
      get = {1'b0, pat[k], 1'b0};
      @(negedge clk);
      checks++;
      if (go[1] !== 1'b1 || beat[1] !== pat[k] || done[1] !== (k == 5)) begin
        errors++; $display("FAIL stall k%0d: got go=%b beat=%b done=%b expected 1 %b %b", k, go[1], beat[1], done[1], pat[k], (k == 5));
      end
    end
    next_cycle; get = 3'b000;
    @(negedge clk);
    checks++; if (go[1] !== 1'b0) begin errors++; $display("FAIL stall_end: got go=%b expected 0", go[1]); end
  endtask

  // ch0 parked in REQ while A(2), B(3), C(1) are pushed; C and a later push while full are dropped
  task automatic test_full;
    int nb;
    apply_reset;
    nb = 0;
    for (int c = 0; c <= 16; c++) begin
      next_cycle;
      job_push = 3'b000;
      case (c)
        0: begin job_push = 3'b001; job_len = 12'h001; end
        2: begin job_push = 3'b001; job_len = 12'h002; end
        3: begin job_push = 3'b001; job_len = 12'h003; end
        4: begin job_push = 3'b001; job_len = 12'h001; end
        7: begin job_push = 3'b001; job_len = 12'h001; end
        default: job_len = 12'h000;
      endcase
      get = (c >= 6) ? 3'b001 : 3'b000;
      @(negedge clk);
      if (beat[0]) nb++;
      if (c >= 4 && c <= 8) begin
        checks++; if (job_full[0] !== (c <= 7)) begin errors++; $display("FAIL full c%0d: got %b expected %b", c, job_full[0], (c <= 7)); end
      end
      if (c >= 6) begin
        checks++; if (done[0] !== (c == 6 || c == 9 || c == 13)) begin
          errors++; $display("FAIL full_done c%0d: got %b expected %b", c, done[0], (c == 6 || c == 9 || c == 13)); end
      end
      if (c >= 14) begin
        checks++; if (go[0] !== 1'b0) begin errors++; $display("FAIL full_idle c%0d: got go=%b expected 0", c, go[0]); end
      end
    end
    checks++; if (nb != 6) begin errors++; $display("FAIL full_beats: got %0d expected 6", nb); end
    get = 3'b000;
  endtask

  task automatic test_round_robin;
    int nb [3];
    int nd [3];
    logic [2:0] prev_done;
    apply_reset;
    for (int i = 0; i < 3; i++) begin nb[i] = 0; nd[i] = 0; end
    prev_done = 3'b000;
    for (int c = 0; c <= 12; c++) begin
      next_cycle;
      job_push = (c == 0) ? 3'b111 : (c == 3) ? 3'b001 : 3'b000;
      job_len  = (c == 3) ? 12'h001 : 12'h222;
      case ((c + 1) % 3)
        0: get = 3'b001;
        1: get = 3'b010;
        default: get = 3'b100;
      endcase
      if (c < 2) get = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (beat[i]) nb[i]++;
        if (done[i]) nd[i]++;
        if (prev_done[i]) begin
          checks++; if (go[i] !== 1'b0) begin errors++; $display("FAIL rr_gap ch%0d c%0d: got go=%b expected 0", i, c, go[i]); end
        end
      end
      prev_done = done;
    end
    checks++; if (nb[0] != 3 || nd[0] != 2) begin errors++; $display("FAIL rr_ch0: got beats=%0d dones=%0d expected 3 2", nb[0], nd[0]); end
    checks++; if (nb[1] != 2 || nd[1] != 1 || nb[2] != 2 || nd[2] != 1) begin
      errors++; $display("FAIL rr_ch12: got %0d/%0d %0d/%0d expected 2/1 2/1", nb[1], nd[1], nb[2], nd[2]); end
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL rr_busy: got %b expected 000", busy); end
    get = 3'b000;
  endtask

`ifdef ARB_REQ_TIMEOUT_EN
  task automatic test_timeout;
    int nd;
    apply_reset;
    nd = 0;
    for (int c = 0; c <= 70; c++) begin
      next_cycle;
      job_push = (c == 0) ? 3'b010 : 3'b000;
      job_len  = 12'h020;
      get      = 3'b000;
      @(negedge clk);
      if (done[1] || beat[1]) nd++;
      if (c == 64) begin
        checks++; if (go[1] !== 1'b1 || err[1] !== 1'b0) begin errors++; $display("FAIL tmo_before: got go=%b err=%b expected 1 0", go[1], err[1]); end
      end
      if (c == 65) begin
        checks++; if (go[1] !== 1'b0 || err[1] !== 1'b1) begin errors++; $display("FAIL tmo_fire: got go=%b err=%b expected 0 1", go[1], err[1]); end
      end
    end
    checks++; if (nd != 0 || err !== 3'b010) begin errors++; $display("FAIL tmo_sticky: got pulses=%0d err=%b expected 0 010", nd, err); end
  endtask
`else
  task automatic test_timeout;
    apply_reset;
    for (int c = 0; c <= 80; c++) begin
      next_cycle;
      job_push = (c == 0) ? 3'b010 : 3'b000;
      job_len  = 12'h020;
      get      = 3'b000;
    end
    @(negedge clk);
    checks++; if (go[1] !== 1'b1 || err !== 3'b000) begin errors++; $display("FAIL notmo_wait: got go=%b err=%b expected 1 000", go[1], err); end
    next_cycle; get = 3'b010;
    @(negedge clk);
    checks++; if (beat[1] !== 1'b1) begin errors++; $display("FAIL notmo_beat: got %b expected 1", beat[1]); end
    get = 3'b000;
  endtask
`endif

  initial begin
    test_reset;
    test_len3;
    test_len16;
    test_stall;
    test_full;
    test_round_robin;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port job_push  input  3  per-channel job enqueue strobe, bit i = channel i.
REQ-004 SHALL have port job_len  input  12  per-channel burst length, bits [4i+3:4i] for channel i; 0 encodes 16 beats.
REQ-005 SHALL have port get  input  3  grant from the round-robin arbiter, bit i = channel i owns the resource this cycle.
REQ-006 SHALL have port go  output  3  request to the arbiter, registered.
REQ-007 SHALL have port beat  output  3  one-cycle pulse per beat transferred on channel i.
REQ-008 SHALL have port done  output  3  one-cycle pulse on the last beat of a burst.
REQ-009 SHALL have port job_full  output  3  channel i job buffer holds 2 entries.
REQ-010 SHALL have port busy  output  3  channel i FSM not IDLE.
REQ-011 SHALL have port err  output  3  sticky grant-timeout flag.

Function
REQ-012 SHALL contain three independent identical channels; per channel a 2-entry FIFO of 4-bit lengths and a 5-bit remaining-beat counter.
REQ-013 SHALL enqueue job_len slice i when job_push[i]=1 and FIFO not full; push while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-014 SHALL run per-channel FSM IDLE -> REQ -> BURST -> IDLE; go[i]=1 in REQ and BURST only.
REQ-015 IDLE: FIFO non-empty -> pop head into remaining (0 -> 16), go to REQ; go rises one cycle after the FIFO becomes non-empty.
REQ-016 REQ: get[i]=1 -> one beat transferred this cycle (beat[i]=1, remaining-1), go to BURST, or straight to IDLE if remaining was 1.
REQ-017 BURST: each cycle with get[i]=1 transfers one beat; get[i]=0 mid-burst SHALL stall (no beat, no count change, go[i] held).
REQ-018 Last beat (remaining 1 -> 0) SHALL assert done[i] with beat[i] and return to IDLE; go[i] SHALL be 0 for at least one cycle between bursts.
REQ-019 beat and done SHALL be combinational from state and get; a burst of length L SHALL produce exactly L beat pulses and one done pulse.
REQ-020 get[i]=1 while go[i]=0 SHALL be ignored (no beat, no state change).
REQ-021 Simultaneous pop and push on one channel SHALL both take effect; FIFO order SHALL be preserved.

Reset
REQ-022 rst=1 at a clock edge SHALL force all FSMs to IDLE, empty all FIFOs, clear remaining counters, err, and timeout counters; go, busy, job_full, err = 0 the following cycle.
REQ-023 Reset mid-burst SHALL abandon the burst without a done pulse; a job_push during rst SHALL be discarded.

Configuration
REQ-024 With ARB_REQ_TIMEOUT_EN defined, a 6-bit per-channel counter SHALL count cycles in REQ; reaching 63 without grant SHALL set err[i], drop the job, return to IDLE (no beat, no done).
REQ-025 The timeout counter SHALL clear on leaving REQ; err[i] SHALL stay set until rst.
REQ-026 Without ARB_REQ_TIMEOUT_EN, err SHALL be constant 0 and REQ SHALL wait indefinitely.

Verification
REQ-027 Push len=3 on ch0, get[0] held 1 -> go[0] 1 for 3 cycles, beat[0] x3, done[0] on third, go[0] 0 next cycle.
REQ-028 Push len=0 on ch2, get[2]=1 -> 16 beats, one done, busy[2] low after.
REQ-029 Ch1 len=4, get[1] pattern 1,0,0,1,1,1 -> beats on cycles 1,4,5,6 only, go[1] held through stall.
REQ-030 Three pushes on ch0 back-to-back with no pop -> job_full[0]=1 after two, third dropped; two bursts then idle.
REQ-031 All channels len=2 with round-robin grants -> each channel two beats, one done, go gap of one cycle min between bursts.
REQ-032 With ARB_REQ_TIMEOUT_EN, push ch1, get=0 for 63 cycles -> err[1]=1, go[1]=0, no done; rst mid-burst -> all outputs 0 next cycle.
